// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage feeding the control decoder.
//               Holds the program counter, drives a synchronous-read
//               instruction ROM and presents each 9-bit instruction with a
//               valid flag. Taken branches from the decoder are resolved
//               through a writable target LUT; the sequential fetch already
//               in flight is squashed. Runs from a start pulse until the
//               instruction at prog_end retires without branching.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               start             - one-cycle pulse, begin at RESET_PC
//               stall             - freeze fetch, hold current instruction
//               prog_end          - address of the last program instruction
//               branch_en/idx     - taken flag and LUT index from decoder
//               lut_we/waddr/wdata- branch-target LUT write port
//               imem_addr/en      - ROM read address / enable
//               imem_rdata        - ROM data (one cycle after addr/en)
//               instr/instr_valid/instr_pc - instruction to the decoder
//               done              - program finished
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 32,
    parameter int RESET_PC  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic [PC_W-1:0] prog_end,
    input  logic            branch_en,
    input  logic [4:0]      branch_idx,
    input  logic            lut_we,
    input  logic [4:0]      lut_waddr,
    input  logic [PC_W-1:0] lut_wdata,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_en,
    input  logic [8:0]      imem_rdata,
    output logic [8:0]      instr,
    output logic            instr_valid,
    output logic [PC_W-1:0] instr_pc,
    output logic            done
);

    localparam logic [PC_W-1:0] c_resetPc = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] c_pcOne   = PC_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [PC_W-1:0] r_fetchPc;
    logic [PC_W-1:0] w_fetchPcNext;
    logic [PC_W-1:0] r_instrPc;
    logic [PC_W-1:0] w_instrPcNext;
    logic            r_instrValid;
    logic            w_instrValidNext;
    logic            w_imemEn;
    logic            w_done;
    logic [PC_W-1:0] w_lutTarget;

    // Branch-target LUT: no reset, contents are defined only once written.
    logic [PC_W-1:0] r_lut [LUT_DEPTH];

    always_ff @(posedge clk) begin
        if (lut_we) begin
            r_lut[lut_waddr] <= lut_wdata;
        end
    end

    // Combinational read: a write to the same index in the same cycle only
    // lands at the clock edge, so a concurrent redirect sees the old entry.
    assign w_lutTarget = r_lut[branch_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_fetchPc    <= c_resetPc;
            r_instrPc    <= '0;
            r_instrValid <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_fetchPc    <= w_fetchPcNext;
            r_instrPc    <= w_instrPcNext;
            r_instrValid <= w_instrValidNext;
        end
    end

    always_comb begin
        w_stateNext      = r_state;
        w_fetchPcNext    = r_fetchPc;
        w_instrPcNext    = r_instrPc;
        w_instrValidNext = r_instrValid;
        w_imemEn         = 1'b0;
        w_done           = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_fetchPcNext    = c_resetPc;
                    w_instrValidNext = 1'b0;
                    w_stateNext      = RUN;
                end
            end

            RUN: begin
                // With the ROM disabled its output register holds, so the
                // instruction on display stays stable through a stall.
                w_imemEn = ~stall;
                if (!stall) begin
                    // Address issued this cycle becomes the instruction next
                    // cycle.
                    w_instrPcNext    = r_fetchPc;
                    w_instrValidNext = 1'b1;
                    w_fetchPcNext    = r_fetchPc + c_pcOne;
                    if (r_instrValid) begin
                        if (branch_en) begin
                            // The sequential fetch issued now is wrong-path:
                            // mark it invalid and redirect.
                            w_fetchPcNext    = w_lutTarget;
                            w_instrValidNext = 1'b0;
                        end else if (r_instrPc == prog_end) begin
                            w_instrValidNext = 1'b0;
                            w_stateNext      = DONE;
                        end
                    end
                end
            end

            DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_fetchPcNext    = c_resetPc;
                    w_instrValidNext = 1'b0;
                    w_stateNext      = RUN;
                end
            end

            default: begin
                w_stateNext      = IDLE;
                w_instrValidNext = 1'b0;
            end
        endcase
    end

    assign imem_addr   = r_fetchPc;
    assign imem_en     = w_imemEn;
    assign instr       = imem_rdata;
    assign instr_valid = r_instrValid;
    assign instr_pc    = r_instrPc;
    assign done        = w_done;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A behavioural ROM with a
//               known content pattern sits on the imem port; each scenario
//               pushes the expected per-cycle instruction trace into a queue
//               and pops one entry per cycle as the DUT produces output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int PC_W = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            stall;
    logic [PC_W-1:0] prog_end;
    logic            branch_en;
    logic [4:0]      branch_idx;
    logic            lut_we;
    logic [4:0]      lut_waddr;
    logic [PC_W-1:0] lut_wdata;
    logic [PC_W-1:0] imem_addr;
    logic            imem_en;
    logic [8:0]      imem_rdata;
    logic [8:0]      instr;
    logic            instr_valid;
    logic [PC_W-1:0] instr_pc;
    logic            done;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.PC_W(PC_W), .LUT_DEPTH(32), .RESET_PC(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .prog_end   (prog_end),
        .branch_en  (branch_en),
        .branch_idx (branch_idx),
        .lut_we     (lut_we),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
        .imem_addr  (imem_addr),
        .imem_en    (imem_en),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_pc   (instr_pc),
        .done       (done)
    );

    always #5 clk = ~clk;

    // ROM contents: 37 is odd, so values are distinct over any 512 addresses.
    function automatic logic [8:0] romVal(input int pc);
        return 9'((pc * 37 + 5) % 512);
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= romVal(int'(imem_addr));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Inputs are driven on the falling edge; outputs are observed there too.
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stall = 1'b0; prog_end = '0;
        branch_en = 1'b0; branch_idx = '0;
        lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || done !== 1'b0 || imem_en !== 1'b0 ||
            instr_pc !== 10'd0 || imem_addr !== 10'd0) begin
            failures++;
            $display("FAIL reset_state valid=%b done=%b en=%b pc=%0d addr=%0d expected 0 0 0 0 0",
                     instr_valid, done, imem_en, instr_pc, imem_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_en !== 1'b0 || instr_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold en=%b valid=%b done=%b expected 0 0 0", imem_en, instr_valid, done);
        end
    endtask

    task automatic test_straight();
        int expq[$];
        int e;
        prog_end = 10'd3;
        start = 1'b1;
        expq.push_back(-1);
        for (int p = 0; p <= 3; p++) expq.push_back(p);
        for (int k = 0; expq.size() > 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            e = expq.pop_front();
            checks++;
            if (e < 0) begin
                if (instr_valid !== 1'b0 || done !== 1'b0 || (k == 0 && (imem_en !== 1'b1 || imem_addr !== 10'd0))) begin
                    failures++;
                    $display("FAIL straight_bubble k=%0d valid=%b done=%b en=%b addr=%0d expected valid 0",
                             k, instr_valid, done, imem_en, imem_addr);
                end
            end else if (instr_valid !== 1'b1 || instr_pc !== 10'(e) || instr !== romVal(e) || done !== 1'b0) begin
                failures++;
                $display("FAIL straight_instr k=%0d valid=%b pc=%0d instr=%h expected pc=%0d instr=%h",
                         k, instr_valid, instr_pc, instr, e, romVal(e));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || instr_valid !== 1'b0 || imem_en !== 1'b0) begin
            failures++;
            $display("FAIL straight_done done=%b valid=%b en=%b expected 1 0 0", done, instr_valid, imem_en);
        end
    endtask

    task automatic test_branch();
        int expq[$];
        int e;
        prog_end = 10'd25;
        start = 1'b1;
        lut_we = 1'b1; lut_waddr = 5'd5; lut_wdata = 10'd20;
        expq = {-1, 0, 1, 2, -1};
        for (int p = 20; p <= 25; p++) expq.push_back(p);
        for (int k = 0; expq.size() > 0; k++) begin
            @(negedge clk);
            start = 1'b0; lut_we = 1'b0;
            e = expq.pop_front();
            checks++;
            if (e < 0) begin
                if (instr_valid !== 1'b0 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL branch_bubble k=%0d valid=%b done=%b expected 0 0", k, instr_valid, done);
                end
            end else if (instr_valid !== 1'b1 || instr_pc !== 10'(e) || instr !== romVal(e) || done !== 1'b0) begin
                failures++;
                $display("FAIL branch_instr k=%0d valid=%b pc=%0d instr=%h expected pc=%0d instr=%h",
                         k, instr_valid, instr_pc, instr, e, romVal(e));
            end
            branch_en  = (k == 3);
            branch_idx = 5'd5;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL branch_done done=%b expected 1", done);
        end
    endtask

    task automatic test_stall();
        int expq[$];
        int e;
        prog_end = 10'd25;
        start = 1'b1;
        expq = {-1, 0, 1, 2, 3, 4, 4, 4, 4, 5, 5, 5, -1};
        for (int p = 20; p <= 25; p++) expq.push_back(p);
        for (int k = 0; expq.size() > 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            e = expq.pop_front();
            checks++;
            if (e < 0) begin
                if (instr_valid !== 1'b0 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_bubble k=%0d valid=%b done=%b expected 0 0", k, instr_valid, done);
                end
            end else if (instr_valid !== 1'b1 || instr_pc !== 10'(e) || instr !== romVal(e) || done !== 1'b0) begin
                failures++;
                $display("FAIL stall_instr k=%0d valid=%b pc=%0d instr=%h expected pc=%0d instr=%h",
                         k, instr_valid, instr_pc, instr, e, romVal(e));
            end
            checks++;
            if (imem_en !== ~stall || (k >= 5 && k <= 8 && imem_addr !== 10'd5)) begin
                failures++;
                $display("FAIL stall_imem k=%0d en=%b addr=%0d expected en=%b addr=5 while held",
                         k, imem_en, imem_addr, ~stall);
            end
            if (k == 5) stall = 1'b1;
            if (k == 8) stall = 1'b0;
            if (k == 9) begin stall = 1'b1; branch_en = 1'b1; branch_idx = 5'd5; end
            if (k == 11) stall = 1'b0;
            if (k == 12) branch_en = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL stall_done done=%b expected 1", done);
        end
    endtask

    task automatic test_collision();
        int expq[$];
        int e;
        prog_end = 10'd40;
        start = 1'b1;
        lut_we = 1'b1; lut_waddr = 5'd7; lut_wdata = 10'd10;
        expq = {-1, 0, 1, -1, 10, 11, -1};
        for (int p = 30; p <= 40; p++) expq.push_back(p);
        for (int k = 0; expq.size() > 0; k++) begin
            @(negedge clk);
            start = 1'b0; lut_we = 1'b0;
            e = expq.pop_front();
            checks++;
            if (e < 0) begin
                if (instr_valid !== 1'b0 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL collision_bubble k=%0d valid=%b done=%b expected 0 0", k, instr_valid, done);
                end
            end else if (instr_valid !== 1'b1 || instr_pc !== 10'(e) || instr !== romVal(e) || done !== 1'b0) begin
                failures++;
                $display("FAIL collision_instr k=%0d valid=%b pc=%0d instr=%h expected pc=%0d instr=%h",
                         k, instr_valid, instr_pc, instr, e, romVal(e));
            end
            branch_idx = 5'd7;
            branch_en  = (k == 2 || k == 5);
            if (k == 2) begin lut_we = 1'b1; lut_waddr = 5'd7; lut_wdata = 10'd30; end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL collision_done done=%b expected 1", done);
        end
    endtask

    task automatic test_branch_end();
        int expq[$];
        int e;
        prog_end = 10'd2;
        start = 1'b1;
        lut_we = 1'b1; lut_waddr = 5'd9; lut_wdata = 10'd0;
        expq = {-1, 0, 1, 2, -1, 0, 1, 2};
        for (int k = 0; expq.size() > 0; k++) begin
            @(negedge clk);
            start = 1'b0; lut_we = 1'b0;
            e = expq.pop_front();
            checks++;
            if (e < 0) begin
                if (instr_valid !== 1'b0 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL branch_end_bubble k=%0d valid=%b done=%b expected 0 0", k, instr_valid, done);
                end
            end else if (instr_valid !== 1'b1 || instr_pc !== 10'(e) || instr !== romVal(e) || done !== 1'b0) begin
                failures++;
                $display("FAIL branch_end_instr k=%0d valid=%b pc=%0d instr=%h done=%b expected pc=%0d instr=%h done=0",
                         k, instr_valid, instr_pc, instr, done, e, romVal(e));
            end
            branch_en  = (k == 3);
            branch_idx = 5'd9;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL branch_end_done done=%b valid=%b expected 1 0", done, instr_valid);
        end
    endtask

    task automatic test_reset_midrun();
        int expq[$];
        int e;
        prog_end = 10'd40;
        start = 1'b1;
        expq.push_back(-1);
        for (int p = 0; p <= 6; p++) expq.push_back(p);
        for (int k = 0; expq.size() > 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            e = expq.pop_front();
            checks++;
            if (e < 0) begin
                if (instr_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL midrun_bubble k=%0d valid=%b expected 0", k, instr_valid);
                end
            end else if (instr_valid !== 1'b1 || instr_pc !== 10'(e) || instr !== romVal(e)) begin
                failures++;
                $display("FAIL midrun_instr k=%0d valid=%b pc=%0d instr=%h expected pc=%0d instr=%h",
                         k, instr_valid, instr_pc, instr, e, romVal(e));
            end
        end
        // Reset with start also high and a branch pending: reset must win.
        reset = 1'b1; start = 1'b1; branch_en = 1'b1; branch_idx = 5'd5;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || done !== 1'b0 || imem_en !== 1'b0 || imem_addr !== 10'd0 || instr_pc !== 10'd0) begin
            failures++;
            $display("FAIL midrun_reset valid=%b done=%b en=%b addr=%0d pc=%0d expected 0 0 0 0 0",
                     instr_valid, done, imem_en, imem_addr, instr_pc);
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0; branch_en = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_en !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrun_start_ignored en=%b valid=%b expected 0 0 (still idle)", imem_en, instr_valid);
        end
        start = 1'b1;
        expq = {-1, 0, 1};
        for (int k = 0; expq.size() > 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            e = expq.pop_front();
            checks++;
            if (e < 0) begin
                if (instr_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 10'd0) begin
                    failures++;
                    $display("FAIL resume_bubble k=%0d valid=%b en=%b addr=%0d expected 0 1 0",
                             k, instr_valid, imem_en, imem_addr);
                end
            end else if (instr_valid !== 1'b1 || instr_pc !== 10'(e) || instr !== romVal(e)) begin
                failures++;
                $display("FAIL resume_instr k=%0d valid=%b pc=%0d instr=%h expected pc=%0d instr=%h",
                         k, instr_valid, instr_pc, instr, e, romVal(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_branch();
        test_stall();
        test_collision();
        test_branch_end();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control decoder.
- Holds the program counter and drives a synchronous-read instruction ROM.
- Presents each 9-bit instruction with a valid flag to the decoder.
- Consumes the decoder's branch-taken flag and 5-bit branch-target index, resolving the index through an internal writable target LUT, and squashes the wrong-path fetch.
- Runs from a start pulse to a programmed end address, then reports done.

Parameters:
PC_W, 10, program counter / instruction address width
LUT_DEPTH, 32, branch-target LUT entries (index width = 5)
RESET_PC, 0, first fetch address after start

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins execution from RESET_PC
stall  in  1  freeze fetch and hold the current instruction (downstream busy)
prog_end  in  PC_W  address of the last instruction of the program
branch_en  in  1  branch taken, from the control decoder (valid only while instr_valid)
branch_idx  in  5  branch-target LUT index, from the control decoder
lut_we  in  1  target LUT write enable
lut_waddr  in  5  target LUT write index
lut_wdata  in  PC_W  target LUT write data (absolute PC)
imem_addr  out  PC_W  ROM read address (= fetch_pc)
imem_en  out  1  ROM read enable; ROM output holds when low
imem_rdata  in  9  ROM data, valid the cycle after imem_addr/imem_en
instr  out  9  instruction to the decoder (= imem_rdata)
instr_valid  out  1  instr is live and must be decoded
instr_pc  out  PC_W  address of instr
done  out  1  program finished

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, fetch_pc=RESET_PC, instr_pc=0
  - instr_valid=0, done=0, imem_en=0
  - LUT contents are NOT reset (undefined until written)
- States:
  - IDLE: imem_en=0. On start: fetch_pc<=RESET_PC, go to RUN.
  - RUN: imem_en=~stall; start is ignored.
  - DONE: done=1, instr_valid=0, imem_en=0. On start: clear done, fetch_pc<=RESET_PC, go to RUN.
- Pipeline in RUN: address issued in cycle t; instr is valid in t+1.
  - Each non-stalled cycle: instr_pc<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+1 (wraps modulo 2^PC_W).
  - First cycle after entering RUN: instr_valid=0 (fill bubble).
- Branch resolution: evaluated only when instr_valid=1 and stall=0.
  - If branch_en=1: fetch_pc<=lut[branch_idx], instr_valid<=0 next cycle (squash the sequential fetch already in flight).
  - Net branch penalty: 1 bubble.
- Termination: when instr_valid=1, stall=0, branch_en=0 and instr_pc==prog_end → go to DONE next cycle (done=1). A taken branch on the prog_end instruction redirects and does not terminate.
- Stall: stall=1 freezes fetch_pc, instr_pc, instr_valid and state. imem_en=0 keeps instr stable. branch_en is ignored while stalled and is re-evaluated when stall drops.
- Target LUT:
  - Register array, written on clk when lut_we=1; writes are allowed in any state.
  - Read is combinational on branch_idx.
  - Same-cycle write and redirect on the same index uses the old value.
- Reset asserted mid-run returns to IDLE with reset values regardless of stall or branch.
- branch_en while instr_valid=0 (bubble, IDLE, DONE) has no effect.

Test Plan:
- Straight line: prog_end=3, ROM[0..3]=distinct values, pulse start → instr_valid rises 2 cycles after start; instr_pc 0,1,2,3 on consecutive cycles; done=1 the cycle after instr_pc=3; imem_en=0 in DONE.
- Taken branch: lut[5]=20; assert branch_en with branch_idx=5 while instr_pc=2 → next cycle instr_valid=0 (squashing pc 3); following cycle instr_pc=20, instr_valid=1.
- Stall: assert stall for 3 cycles while instr_pc=4 → instr, instr_pc=4 and instr_valid=1 are held, imem_addr constant; after release instr_pc=5 next cycle. branch_en held high during the stall redirects only after release.
- LUT write/read collision: lut[7]=10, then in one cycle write lut[7]=30 and redirect on idx 7 → fetch goes to 10; a later redirect on idx 7 goes to 30.
- Branch on end: instr_pc==prog_end with branch_en=1, lut target 0 → no done, execution restarts at 0; done asserts only on a non-branching pass of prog_end.
- Reset mid-run: assert reset while instr_valid=1 at pc 6 → next cycle IDLE, instr_valid=0, done=0, fetch_pc=0; start ignored while reset is high; a later start resumes normally.
